// File: rtl/seq_mant_multiplier_if.sv
// Operand/product handshake bundle for the sequential mantissa multiplier.
interface seq_mant_multiplier_if #(parameter int WIDTH = 24);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, flush, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, flush, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_mant_multiplier.sv
// Shift-add mantissa multiplier: one WIDTH+1-bit add per clock, WIDTH iterations per product.
//  state | meaning
//  IDLE  | waiting for an operand pair (in_ready)
//  RUN   | iterating shift-add, one multiplier bit per clock (busy)
//  DONE  | product held until out_ready or flush (out_valid)
module seq_mant_multiplier #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input logic             clk,
  input logic             rst,
  seq_mant_multiplier_if.slave mul
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] product_q;

  logic               accept, zero_op, iterate, last_iter;
  logic [WIDTH:0]     addend, sum;

  assign zero_op   = (mul.a == '0) || (mul.b == '0);
  assign accept    = (state == IDLE) && mul.in_valid && !mul.flush;
  assign iterate   = (state == RUN) && !mul.flush;
  assign last_iter = (cnt == CNT_LAST);

  // acc_hi[WIDTH] is the adder carry; it is shifted down each iteration
  assign addend = acc_lo[0] ? {1'b0, mcand} : '0;
  assign sum    = acc_hi + addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)                        state_nxt = zero_op ? DONE : RUN;
      RUN:  if (mul.flush)                     state_nxt = IDLE;
            else if (last_iter)                state_nxt = DONE;
      DONE: if (mul.flush || mul.out_ready)    state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else if (accept) begin
      if (zero_op) begin
        product_q <= '0;
      end else begin
        mcand  <= mul.a;
        acc_hi <= '0;
        acc_lo <= mul.b;
        cnt    <= '0;
      end
    end else if (iterate) begin
      acc_hi <= {1'b0, sum[WIDTH:1]};
      acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      if (last_iter) product_q <= {sum, acc_lo[WIDTH-1:1]};
    end
  end

  assign mul.in_ready  = (state == IDLE);
  assign mul.out_valid = (state == DONE);
  assign mul.busy      = (state == RUN);
  assign mul.product   = product_q;
endmodule

// File: tb/tb_seq_mant_multiplier.sv
// Scoreboarded bench for seq_mant_multiplier at WIDTH=24.
module tb_seq_mant_multiplier;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_mant_multiplier_if #(.WIDTH(W)) mif ();

  seq_mant_multiplier #(.WIDTH(W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .mul (mif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] last_prod = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] wx, wy;
    wx = {{W{1'b0}}, x};
    wy = {{W{1'b0}}, y};
    return wx * wy;
  endfunction

  // Accept one op, measure edges to out_valid, optionally hold DONE under backpressure.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input int exp_lat, input int hold);
    int lat;
    logic seen_busy;
    logic [2*W-1:0] exp_p;
    chk("idle_ready", mif.in_ready, 1);
    mif.a = op_a;
    mif.b = op_b;
    mif.in_valid = 1'b1;
    mif.out_ready = (hold == 0);
    sb.push_back(model(op_a, op_b));
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    mif.a = W'($urandom);
    mif.b = W'($urandom);
    lat = 0;
    seen_busy = 1'b0;
    while (!mif.out_valid && lat < 100) begin
      seen_busy |= mif.busy;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_seen", seen_busy, exp_lat != 0);
    exp_p = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("product", mif.product, exp_p);
    for (int i = 0; i < hold; i++) begin
      mif.in_valid = 1'b1;
      mif.a = W'($urandom);
      mif.b = W'($urandom);
      @(posedge clk); #1;
      chk("bp_valid", mif.out_valid, 1);
      chk("bp_product", mif.product, exp_p);
      chk("bp_no_accept", mif.in_ready, 0);
    end
    mif.in_valid = 1'b0;
    mif.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("consumed_valid", mif.out_valid, 0);
    chk("consumed_ready", mif.in_ready, 1);
    chk("product_held", mif.product, exp_p);
    mif.out_ready = 1'b0;
    last_prod = exp_p;
  endtask

  initial begin
    int viol;
    mif.in_valid  = 1'b0;
    mif.a         = '0;
    mif.b         = '0;
    mif.flush     = 1'b0;
    mif.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", mif.in_ready, 1);
    chk("rst_out_valid", mif.out_valid, 0);
    chk("rst_busy", mif.busy, 0);
    chk("rst_product", mif.product, 0);
    #12 rst = 1'b0;
    @(posedge clk); #1;

    run_op(24'h0000FF, 24'h0000FF, W, 0);
    run_op(24'h800000, 24'h800000, W, 0);
    run_op(24'hFFFFFF, 24'hFFFFFF, W, 0);
    run_op(24'h000000, 24'hABCDEF, 0, 0);
    run_op(24'hABCDEF, 24'h000000, 0, 0);
    run_op(24'h000001, 24'h123456, W, 0);
    run_op(24'h654321, 24'h000001, W, 0);
    for (int i = 0; i < 4; i++)
      run_op(W'($urandom_range(32'hFFFFFF, 1)), W'($urandom_range(32'hFFFFFF, 1)), W, 0);
    run_op(24'hC0FFEE, 24'h0BEEF1, W, 10);
    run_op(24'h000000, 24'h000005, 0, 3);

    // async reset in the middle of an op: op is lost
    run_op(24'h9ABCDE, 24'h876543, W, 0);
    mif.a = 24'hFEDCBA;
    mif.b = 24'h13579B;
    mif.in_valid = 1'b1;
    sb.push_back(model(mif.a, mif.b));
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", mif.in_ready, 1);
    chk("mid_rst_out_valid", mif.out_valid, 0);
    chk("mid_rst_busy", mif.busy, 0);
    chk("mid_rst_product", mif.product, 0);
    void'(sb.pop_back());
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run_op(24'd3, 24'd5, W, 0);

    // flush during RUN
    mif.a = 24'h111111;
    mif.b = 24'h222222;
    mif.in_valid = 1'b1;
    sb.push_back(model(mif.a, mif.b));
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 mif.flush = 1'b1;
    @(posedge clk); #1;
    mif.flush = 1'b0;
    void'(sb.pop_back());
    chk("flush_idle", mif.in_ready, 1);
    chk("flush_busy", mif.busy, 0);
    chk("flush_product", mif.product, last_prod);
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (mif.out_valid || mif.busy) viol++;
    end
    chk("flush_no_valid", 64'(viol), 0);

    // flush beats in_valid in IDLE
    mif.flush = 1'b1;
    mif.in_valid = 1'b1;
    mif.a = 24'd7;
    mif.b = 24'd9;
    @(posedge clk); #1;
    mif.flush = 1'b0;
    mif.in_valid = 1'b0;
    chk("flush_idle_ready", mif.in_ready, 1);
    chk("flush_idle_busy", mif.busy, 0);
    chk("flush_idle_valid", mif.out_valid, 0);

    // flush in DONE drops the product without consuming it
    mif.a = 24'd6;
    mif.b = 24'd0;
    mif.in_valid = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    chk("zero_done_valid", mif.out_valid, 1);
    mif.flush = 1'b1;
    @(posedge clk); #1;
    mif.flush = 1'b0;
    chk("flush_done_valid", mif.out_valid, 0);
    chk("flush_done_ready", mif.in_ready, 1);

    run_op(24'd11, 24'd13, W, 0);
    chk("sb_empty", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
